product_out_buf: RTL and testbench

- Output-side counterpart to the operand load registers of the radix-16 Booth multiplier.
- Captures each signed 2*WIDTH-bit product the core presents with a completion strobe.
- Buffers products in a small first-word-fall-through (FWFT) FIFO.
- Hands products to the downstream consumer over a valid/ready handshake, and back-pressures the core through a registered ready.

---
 rtl/product_out_buf_if.sv | 34 +++
 rtl/product_out_buf.sv | 86 ++++++++
 tb/tb_product_out_buf.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/product_out_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : product_out_buf_if
//  Purpose  : Handshake bundle between the multiplier core / consumer side
//             (master) and the product output buffer (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface product_out_buf_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
);
    logic                          flush_i;
    logic                          prod_valid_i;
    logic signed [2*WIDTH-1:0]     prod_i;
    logic                          prod_ready_o;
    logic                          out_valid_o;
    logic signed [2*WIDTH-1:0]     out_data_o;
    logic                          out_ready_i;
    logic [$clog2(DEPTH+1)-1:0]    count_o;
    logic                          overflow_o;

    // Driver side: core strobes products in, consumer pulls them out
    modport master (
        output flush_i, prod_valid_i, prod_i, out_ready_i,
        input  prod_ready_o, out_valid_o, out_data_o, count_o, overflow_o
    );

    // Buffer side
    modport slave (
        input  flush_i, prod_valid_i, prod_i, out_ready_i,
        output prod_ready_o, out_valid_o, out_data_o, count_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/product_out_buf.sv
`default_nettype none
// ============================================================================
//  Module   : product_out_buf
//  Purpose  : FWFT FIFO capturing signed 2*WIDTH-bit products from the Booth
//             multiplier core and delivering them over valid/ready. Ready
//             toward the core comes from registered count only.
//  Revision : 1.0  initial release
// ============================================================================
module product_out_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    product_out_buf_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic signed [2*WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]             r_rd_ptr;
    logic [PW-1:0]             r_wr_ptr;
    logic [CW-1:0]             r_count;
    logic                      r_overflow;

    logic w_valid;
    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Status and handshake qualification; flush suppresses both sides
    always_comb begin
        w_valid = (r_count != '0);
        w_ready = (r_count != C_FULL);
        w_push  = bus.prod_valid_i & w_ready & ~bus.flush_i;
        w_pop   = w_valid & bus.out_ready_i & ~bus.flush_i;
        w_drop  = bus.prod_valid_i & ~w_ready & ~bus.flush_i;
    end

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= bus.prod_i;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head is presented directly from storage; zero while empty
    assign bus.out_valid_o  = w_valid;
    assign bus.out_data_o   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.prod_ready_o = w_ready;
    assign bus.count_o      = r_count;
    assign bus.overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_product_out_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_product_out_buf
//  Purpose  : Scoreboard bench for product_out_buf: directed scenarios plus
//             randomized traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_product_out_buf;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;

    product_out_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    product_out_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [2*WIDTH-1:0] sb_q[$];   // expected outputs in push order
    int                 m_cnt;     // expected occupancy
    logic               m_ovf;     // expected sticky overflow
    logic               mon_en;
    logic               chk_zero;

    int errors;
    int checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: apply inputs, predict acceptance from the model, advance edge
    task automatic step(input logic v, input logic [31:0] d, input logic r,
                        input logic f, input logic rs);
        logic acc_push, acc_pop, ovf_set;
        bus.prod_valid_i = v;
        bus.prod_i       = d;
        bus.out_ready_i  = r;
        bus.flush_i      = f;
        rst              = rs;
        acc_push = v && (m_cnt < DEPTH) && !f && !rs;
        acc_pop  = (m_cnt > 0) && r && !f && !rs;
        ovf_set  = v && (m_cnt == DEPTH) && !f && !rs;
        if (acc_push) sb_q.push_back(d);
        @(posedge clk);
        if (rs) begin
            m_cnt = 0; m_ovf = 1'b0; sb_q.delete(); chk_zero = 1'b1;
        end else if (f) begin
            m_cnt = 0; sb_q.delete();
        end else begin
            m_cnt = m_cnt + (acc_push ? 1 : 0) - (acc_pop ? 1 : 0);
            if (ovf_set) m_ovf = 1'b1;
        end
        #1;
    endtask

    // Monitor: compare DUT state and head data against the model
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 32'(bus.count_o), 32'(m_cnt));
            chk("out_valid", 32'(bus.out_valid_o), 32'(m_cnt != 0));
            chk("prod_ready", 32'(bus.prod_ready_o), 32'(m_cnt < DEPTH));
            chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
            chk("inv_valid", 32'(bus.out_valid_o), 32'(bus.count_o != 0));
            chk("inv_ready", 32'(bus.prod_ready_o), 32'(bus.count_o != DEPTH));
            if (chk_zero) begin
                chk("reset_data", bus.out_data_o, 32'h0);
                chk_zero = 1'b0;
            end
            if (bus.out_valid_o) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL head_unexpected: got %h expected none", bus.out_data_o);
                end else begin
                    chk("head_data", bus.out_data_o, sb_q[0]);
                    if (bus.out_ready_i && !bus.flush_i && !rst) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        errors = 0; checks = 0;
        mon_en = 1'b0; chk_zero = 1'b0;
        m_cnt = 0; m_ovf = 1'b0;
        bus.prod_valid_i = 1'b0; bus.prod_i = '0; bus.out_ready_i = 1'b0;
        bus.flush_i = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 1);
        mon_en = 1'b1;

        // Single product with consumer ready
        step(1, 32'hFFFF_FFF1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Fill under back-pressure, hold head, then overflow attempts
        step(1, 32'h0000_0006, 0, 0, 0);
        step(1, 32'h7FFF_0001, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 32'hDEAD_BEEF, 0, 0, 0);
        step(1, 32'hDEAD_BEEF, 1, 0, 0);   // full + pop: still no room this cycle
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 32'h0000_0042, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Simultaneous push/pop at count 1, exercising pointer wrap
        step(1, 32'h0000_0100, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(1, 32'(i), 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Flush with a coincident push keeps overflow; reset clears it
        step(1, 32'h1111_1111, 0, 0, 0);
        step(1, 32'h2222_2222, 0, 0, 0);
        step(1, 32'h3333_3333, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Reset while full with consumer ready
        step(1, 32'hAAAA_0001, 0, 0, 0);
        step(1, 32'hAAAA_0002, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 80) == 0);
        end
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
